// File: rtl/iter_2d_scan_pkg.sv
// Shared types and helpers for the 2-D raster scan sequencer.
// The FSM state encoding lives here so the top and any future siblings agree on it.
package iter_2d_scan_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Counter width for an inclusive 0..max_val range; a zero-span axis still needs one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/iter_2d_scan_axis.sv
// One axis counter of the scan: counts 0..MAX on inc and wraps by compare.
// clr returns to 0 regardless of inc; at_max flags the last value of the axis.
module iter_2d_scan_axis
  import iter_2d_scan_pkg::*;
#(
  parameter  int MAX = 1,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign at_max = (val == MAX_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (inc) begin
      val <= at_max ? '0 : val + 1'b1;
    end
  end

endmodule

// File: rtl/iter_2d_scan.sv
// Row-major (x fastest) coordinate sequencer with valid/ready output,
// first/last beat markers, a one-cycle done pulse and optional free-running mode.
module iter_2d_scan
  import iter_2d_scan_pkg::*;
#(
  parameter  int X_MAX      = 639,
  parameter  int Y_MAX      = 479,
  parameter  int CONTINUOUS = 0,
  localparam int XW         = cnt_width(X_MAX),
  localparam int YW         = cnt_width(Y_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_first,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_t state;
  logic   beat;
  logic   stop_run;
  logic   x_inc;
  logic   y_inc;
  logic   x_at_max;
  logic   y_at_max;

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign beat      = out_valid & out_ready;
  assign stop_run  = out_valid & stop;

  // stop wins over a same-cycle beat: the beat is still delivered, but not advanced past.
  assign x_inc = beat & ~stop_run;
  assign y_inc = x_inc & x_at_max;

  iter_2d_scan_axis #(.MAX(X_MAX)) u_x_axis (
    .clk    (clk),
    .reset  (reset),
    .clr    (stop_run),
    .inc    (x_inc),
    .val    (out_x),
    .at_max (x_at_max)
  );

  iter_2d_scan_axis #(.MAX(Y_MAX)) u_y_axis (
    .clk    (clk),
    .reset  (reset),
    .clr    (stop_run),
    .inc    (y_inc),
    .val    (out_y),
    .at_max (y_at_max)
  );

  assign out_first = out_valid & (out_x == '0) & (out_y == '0);
  assign out_last  = out_valid & x_at_max & y_at_max;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (beat && x_at_max && y_at_max) begin
            done <= 1'b1;
            if (CONTINUOUS == 0) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_2d_scan.sv
// Self-checking bench for iter_2d_scan: three configurations (3x2 one-shot, 3x2 continuous, 0x0)
// driven by directed steps, with a beat scoreboard fed from a reference raster model.
module tb_iter_2d_scan;

  localparam int XM [3] = '{3, 3, 0};
  localparam int YM [3] = '{2, 2, 0};

  typedef struct {
    int x;
    int y;
    bit first;
    bit last;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       start [3];
  logic       stop  [3];
  logic       ready [3];
  logic       valid [3];
  logic       first [3];
  logic       last  [3];
  logic       busy  [3];
  logic       done  [3];
  logic [1:0] ox    [3];
  logic [1:0] oy    [3];
  logic       x2;
  logic       y2;

  assign ox[2] = {1'b0, x2};
  assign oy[2] = {1'b0, y2};

  int    vectors     = 0;
  int    miscompares = 0;
  bit    pend_done   = 1'b0;
  beat_t sb[$];

  iter_2d_scan #(.X_MAX(3), .Y_MAX(2), .CONTINUOUS(0)) u_once (
    .clk(clk), .reset(rst_n), .start(start[0]), .stop(stop[0]), .out_ready(ready[0]),
    .out_valid(valid[0]), .out_x(ox[0]), .out_y(oy[0]), .out_first(first[0]),
    .out_last(last[0]), .busy(busy[0]), .done(done[0])
  );

  iter_2d_scan #(.X_MAX(3), .Y_MAX(2), .CONTINUOUS(1)) u_cont (
    .clk(clk), .reset(rst_n), .start(start[1]), .stop(stop[1]), .out_ready(ready[1]),
    .out_valid(valid[1]), .out_x(ox[1]), .out_y(oy[1]), .out_first(first[1]),
    .out_last(last[1]), .busy(busy[1]), .done(done[1])
  );

  iter_2d_scan #(.X_MAX(0), .Y_MAX(0), .CONTINUOUS(0)) u_dot (
    .clk(clk), .reset(rst_n), .start(start[2]), .stop(stop[2]), .out_ready(ready[2]),
    .out_valid(valid[2]), .out_x(x2), .out_y(y2), .out_first(first[2]),
    .out_last(last[2]), .busy(busy[2]), .done(done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int s);
    beat_t e;
    for (int y = 0; y <= YM[s]; y++) begin
      for (int x = 0; x <= XM[s]; x++) begin
        e.x     = x;
        e.y     = y;
        e.first = (x == 0) && (y == 0);
        e.last  = (x == XM[s]) && (y == YM[s]);
        sb.push_back(e);
      end
    end
  endtask

  // Sample at the falling edge, score any beat about to transfer, then step past the next rising edge.
  task automatic tick(input int s);
    beat_t e;
    @(negedge clk);
    check("done", 32'(done[s]), 32'(pend_done));
    pend_done = 1'b0;
    if (!valid[s]) begin
      check("first_qual", 32'(first[s]), 0);
      check("last_qual", 32'(last[s]), 0);
    end else if (ready[s]) begin
      if (sb.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        check("beat_x", 32'(ox[s]), e.x);
        check("beat_y", 32'(oy[s]), e.y);
        check("beat_first", 32'(first[s]), 32'(e.first));
        check("beat_last", 32'(last[s]), 32'(e.last));
        if (e.last && !stop[s]) pend_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input int s);
    int n;
    n = (XM[s] + 1) * (YM[s] + 1);
    push_frame(s);
    start[s] = 1'b1;
    tick(s);
    start[s] = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("valid_run", 32'(valid[s]), 1);
      tick(s);
    end
    check("busy_after_frame", 32'(busy[s]), 0);
    check("sb_empty", sb.size(), 0);
    tick(s);
    check("done_one_cycle", 32'(done[s]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start[s] = 1'b0;
      stop[s]  = 1'b0;
      ready[s] = 1'b1;
    end

    // Reset state of every configuration.
    #12;
    for (int s = 0; s < 3; s++) begin
      check("rst_valid", 32'(valid[s]), 0);
      check("rst_busy", 32'(busy[s]), 0);
      check("rst_done", 32'(done[s]), 0);
      check("rst_x", 32'(ox[s]), 0);
      check("rst_y", 32'(oy[s]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame with the consumer always ready.
    run_full(0);

    // Backpressure pattern 1,0,0,1,...: sequence must match exactly, no skips or repeats.
    push_frame(0);
    start[0] = 1'b1;
    tick(0);
    start[0] = 1'b0;
    for (int c = 0; c < 200 && sb.size() > 0; c++) begin
      ready[0] = (c % 3 == 0);
      tick(0);
    end
    check("bp_drained", sb.size(), 0);
    ready[0] = 1'b1;
    tick(0);

    // Stop on the (2,1) beat: beat is delivered, counters clear, no done.
    push_frame(0);
    start[0] = 1'b1;
    tick(0);
    start[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick(0);
    stop[0] = 1'b1;
    tick(0);
    stop[0] = 1'b0;
    sb.delete();
    check("stop_valid", 32'(valid[0]), 0);
    check("stop_x", 32'(ox[0]), 0);
    check("stop_y", 32'(oy[0]), 0);
    tick(0);
    run_full(0);

    // Continuous mode: two frames back to back, start during RUN ignored.
    push_frame(1);
    push_frame(1);
    push_frame(1);
    start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      check("cont_busy", 32'(busy[1]), 1);
      start[1] = (i == 7);
      tick(1);
    end
    start[1] = 1'b0;
    stop[1]  = 1'b1;
    tick(1);
    stop[1] = 1'b0;
    sb.delete();
    check("cont_stopped", 32'(busy[1]), 0);
    tick(1);

    // Asynchronous reset between clock edges in the middle of a frame.
    push_frame(0);
    start[0] = 1'b1;
    tick(0);
    start[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick(0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid[0]), 0);
    check("arst_busy", 32'(busy[0]), 0);
    check("arst_x", 32'(ox[0]), 0);
    check("arst_y", 32'(oy[0]), 0);
    check("arst_done", 32'(done[0]), 0);
    #1;
    rst_n = 1'b1;
    sb.delete();
    pend_done = 1'b0;
    @(posedge clk);
    #1;
    tick(0);

    // Degenerate 1x1 rectangle: single beat with both markers, then done.
    run_full(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
